// File: rtl/reorder_buffer_pkg.sv
// Shared types and defaults for the reorder buffer: entry kinds, entry record and
// the redirect-PC helper used on a branch mispredict.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_DEF = 16;
  localparam int IDX_W_DEF    = 4;

  typedef enum logic [1:0] {
    ROB_REG = 2'd0,
    ROB_BR  = 2'd1,
    ROB_ST  = 2'd2
  } rob_type_e;

  typedef struct packed {
    rob_type_e   kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] target;
  } rob_entry_t;

  function automatic logic [31:0] redirect_pc(input logic        taken,
                                              input logic [31:0] pc,
                                              input logic [31:0] target);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, captures RS/LSB results, commits at head
// to regfile / store queue / branch predictor and flushes everything on a mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  output logic             rob_full,
  output logic [IDX_W-1:0] rob_tail_idx,
  input  logic             de_in_en,
  input  logic [1:0]       de_type_in,
  input  logic [4:0]       de_rd_in,
  input  logic [31:0]      de_pc_in,
  input  logic             de_pred_in,
  input  logic [31:0]      de_target_in,
  input  logic [IDX_W-1:0] q1_idx_in,
  input  logic [IDX_W-1:0] q2_idx_in,
  output logic             q1_rdy_out,
  output logic             q2_rdy_out,
  output logic [31:0]      q1_val_out,
  output logic [31:0]      q2_val_out,
  input  logic             rs_in_en,
  input  logic [IDX_W-1:0] rs_rob_idx_in,
  input  logic [31:0]      rs_val_in,
  input  logic             lsb_in_en,
  input  logic [IDX_W-1:0] lsb_rob_idx_in,
  input  logic [31:0]      lsb_val_in,
  output logic             commit_reg_en,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic [IDX_W-1:0] commit_rob_idx,
  output logic             commit_st_en,
  output logic             bp_upd_en,
  output logic [31:0]      bp_pc,
  output logic             bp_taken,
  output logic             roll_back,
  output logic [31:0]      roll_back_pc
);

  localparam int CNT_W = IDX_W + 1;

  rob_entry_t          r_ent [ROB_SIZE];
  logic [31:0]         r_val [ROB_SIZE];
  logic [ROB_SIZE-1:0] r_ready;
  logic [IDX_W-1:0]    r_head;
  logic [IDX_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  logic             r_commit_reg_en;
  logic [4:0]       r_commit_rd;
  logic [31:0]      r_commit_val;
  logic [IDX_W-1:0] r_commit_rob_idx;
  logic             r_commit_st_en;
  logic             r_bp_upd_en;
  logic [31:0]      r_bp_pc;
  logic             r_bp_taken;
  logic             r_roll_back;
  logic [31:0]      r_roll_back_pc;

  logic        w_live;
  logic        w_disp;
  logic        w_rs_wr;
  logic        w_lsb_wr;
  logic        w_commit;
  logic        w_taken;
  logic        w_flush;
  rob_entry_t  w_head_ent;
  logic [31:0] w_head_val;

  // Inputs seen during the roll_back cycle belong to the squashed path.
  assign w_live     = rdy_in & ~r_roll_back;
  assign w_disp     = w_live & de_in_en;
  assign w_rs_wr    = w_live & rs_in_en;
  assign w_lsb_wr   = w_live & lsb_in_en;
  assign w_head_ent = r_ent[r_head];
  assign w_head_val = r_val[r_head];
  assign w_commit   = w_live & (r_count != '0) & r_ready[r_head];
  assign w_taken    = w_head_val[0];
  assign w_flush    = w_commit & (w_head_ent.kind == ROB_BR) & (w_taken != w_head_ent.pred);

  always_ff @(posedge clk) begin
    if (w_disp) begin
      r_ent[r_tail].kind   <= rob_type_e'(de_type_in);
      r_ent[r_tail].rd     <= de_rd_in;
      r_ent[r_tail].pc     <= de_pc_in;
      r_ent[r_tail].pred   <= de_pred_in;
      r_ent[r_tail].target <= de_target_in;
    end
    if (w_rs_wr) begin
      r_val[rs_rob_idx_in] <= rs_val_in;
    end
    if (w_lsb_wr) begin
      r_val[lsb_rob_idx_in] <= lsb_val_in;
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_ready          <= '0;
      r_commit_reg_en  <= 1'b0;
      r_commit_rd      <= '0;
      r_commit_val     <= '0;
      r_commit_rob_idx <= '0;
      r_commit_st_en   <= 1'b0;
      r_bp_upd_en      <= 1'b0;
      r_bp_pc          <= '0;
      r_bp_taken       <= 1'b0;
      r_roll_back      <= 1'b0;
      r_roll_back_pc   <= '0;
    end else if (!rdy_in) begin
      r_commit_reg_en <= 1'b0;
      r_commit_st_en  <= 1'b0;
      r_bp_upd_en     <= 1'b0;
      r_roll_back     <= 1'b0;
    end else begin
      r_commit_reg_en <= 1'b0;
      r_commit_st_en  <= 1'b0;
      r_bp_upd_en     <= 1'b0;
      r_roll_back     <= 1'b0;

      if (w_commit) begin
        r_commit_rob_idx <= r_head;
        if (w_head_ent.kind == ROB_REG) begin
          r_commit_reg_en <= (w_head_ent.rd != 5'd0);
          r_commit_rd     <= w_head_ent.rd;
          r_commit_val    <= w_head_val;
        end else if (w_head_ent.kind == ROB_ST) begin
          r_commit_st_en <= 1'b1;
        end else if (w_head_ent.kind == ROB_BR) begin
          r_bp_upd_en <= 1'b1;
          r_bp_pc     <= w_head_ent.pc;
          r_bp_taken  <= w_taken;
        end
      end

      if (w_flush) begin
        r_roll_back    <= 1'b1;
        r_roll_back_pc <= redirect_pc(w_taken, w_head_ent.pc, w_head_ent.target);
        r_head         <= '0;
        r_tail         <= '0;
        r_count        <= '0;
        r_ready        <= '0;
      end else begin
        if (w_disp) begin
          r_tail          <= r_tail + IDX_W'(1);
          r_ready[r_tail] <= 1'b0;
        end
        if (w_commit) begin
          r_head          <= r_head + IDX_W'(1);
          r_ready[r_head] <= 1'b0;
        end
        if (w_rs_wr) begin
          r_ready[rs_rob_idx_in] <= 1'b1;
        end
        if (w_lsb_wr) begin
          r_ready[lsb_rob_idx_in] <= 1'b1;
        end
        r_count <= r_count + CNT_W'(w_disp) - CNT_W'(w_commit);
      end
    end
  end

  // Operand lookup: a result on the CDB this cycle wins over the stored copy.
  always_comb begin
    q1_rdy_out = 1'b0;
    q1_val_out = '0;
    if (rs_in_en && (rs_rob_idx_in == q1_idx_in)) begin
      q1_rdy_out = 1'b1;
      q1_val_out = rs_val_in;
    end else if (lsb_in_en && (lsb_rob_idx_in == q1_idx_in)) begin
      q1_rdy_out = 1'b1;
      q1_val_out = lsb_val_in;
    end else if (r_ready[q1_idx_in]) begin
      q1_rdy_out = 1'b1;
      q1_val_out = r_val[q1_idx_in];
    end
  end

  always_comb begin
    q2_rdy_out = 1'b0;
    q2_val_out = '0;
    if (rs_in_en && (rs_rob_idx_in == q2_idx_in)) begin
      q2_rdy_out = 1'b1;
      q2_val_out = rs_val_in;
    end else if (lsb_in_en && (lsb_rob_idx_in == q2_idx_in)) begin
      q2_rdy_out = 1'b1;
      q2_val_out = lsb_val_in;
    end else if (r_ready[q2_idx_in]) begin
      q2_rdy_out = 1'b1;
      q2_val_out = r_val[q2_idx_in];
    end
  end

  // Two entries of slack so the decoder can still land one dispatch after seeing full.
  assign rob_full       = (r_count >= CNT_W'(ROB_SIZE - 2));
  assign rob_tail_idx   = r_tail;
  assign commit_reg_en  = r_commit_reg_en;
  assign commit_rd      = r_commit_rd;
  assign commit_val     = r_commit_val;
  assign commit_rob_idx = r_commit_rob_idx;
  assign commit_st_en   = r_commit_st_en;
  assign bp_upd_en      = r_bp_upd_en;
  assign bp_pc          = r_bp_pc;
  assign bp_taken       = r_bp_taken;
  assign roll_back      = r_roll_back;
  assign roll_back_pc   = r_roll_back_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued at dispatch in
// program order and a negedge monitor checks every commit/branch pulse against them.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        rob_full;
  logic [3:0]  rob_tail_idx;
  logic        de_in_en = 1'b0;
  logic [1:0]  de_type_in = '0;
  logic [4:0]  de_rd_in = '0;
  logic [31:0] de_pc_in = '0;
  logic        de_pred_in = 1'b0;
  logic [31:0] de_target_in = '0;
  logic [3:0]  q1_idx_in = '0;
  logic [3:0]  q2_idx_in = '0;
  logic        q1_rdy_out, q2_rdy_out;
  logic [31:0] q1_val_out, q2_val_out;
  logic        rs_in_en = 1'b0;
  logic [3:0]  rs_rob_idx_in = '0;
  logic [31:0] rs_val_in = '0;
  logic        lsb_in_en = 1'b0;
  logic [3:0]  lsb_rob_idx_in = '0;
  logic [31:0] lsb_val_in = '0;
  logic        commit_reg_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_idx;
  logic        commit_st_en;
  logic        bp_upd_en;
  logic [31:0] bp_pc;
  logic        bp_taken;
  logic        roll_back;
  logic [31:0] roll_back_pc;

  reorder_buffer #(.ROB_SIZE(16), .IDX_W(4)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_full(rob_full), .rob_tail_idx(rob_tail_idx),
    .de_in_en(de_in_en), .de_type_in(de_type_in), .de_rd_in(de_rd_in),
    .de_pc_in(de_pc_in), .de_pred_in(de_pred_in), .de_target_in(de_target_in),
    .q1_idx_in(q1_idx_in), .q2_idx_in(q2_idx_in),
    .q1_rdy_out(q1_rdy_out), .q2_rdy_out(q2_rdy_out),
    .q1_val_out(q1_val_out), .q2_val_out(q2_val_out),
    .rs_in_en(rs_in_en), .rs_rob_idx_in(rs_rob_idx_in), .rs_val_in(rs_val_in),
    .lsb_in_en(lsb_in_en), .lsb_rob_idx_in(lsb_rob_idx_in), .lsb_val_in(lsb_val_in),
    .commit_reg_en(commit_reg_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_idx(commit_rob_idx), .commit_st_en(commit_st_en),
    .bp_upd_en(bp_upd_en), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .roll_back(roll_back), .roll_back_pc(roll_back_pc)
  );

  always #5 clk = ~clk;

  // kind: 0 = REG, 1 = BR, 2 = ST
  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  idx;
    logic [31:0] pc;
    logic        taken;
    logic        rb;
    logic [31:0] rb_pc;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  pending[$];
  logic [31:0] res_val [16];
  int          tail_m = 0;
  bit          stop_disp = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; a roll_back cycle is sat out with idle inputs.
  task automatic step();
    @(posedge clk);
    #1;
    de_in_en  = 1'b0;
    rs_in_en  = 1'b0;
    lsb_in_en = 1'b0;
    if (roll_back) begin
      tail_m    = 0;
      stop_disp = 0;
      @(posedge clk);
      #1;
    end
    chk("tail_idx", 32'(rob_tail_idx), 32'(tail_m));
  endtask

  task automatic disp(input int kind, input logic [4:0] rd, input logic [31:0] pc,
                      input logic pred, input logic [31:0] target, input logic [31:0] val);
    exp_t e;
    de_in_en     = 1'b1;
    de_type_in   = 2'(kind);
    de_rd_in     = rd;
    de_pc_in     = pc;
    de_pred_in   = pred;
    de_target_in = target;
    res_val[tail_m] = val;
    pending.push_back(4'(tail_m));
    e.kind  = kind;
    e.rd    = rd;
    e.val   = val;
    e.idx   = 4'(tail_m);
    e.pc    = pc;
    e.taken = val[0];
    e.rb    = (kind == 1) && (val[0] != pred);
    e.rb_pc = val[0] ? target : pc + 32'd4;
    if (!(kind == 0 && rd == 5'd0)) sb.push_back(e);
    if (e.rb) stop_disp = 1;
    tail_m = (tail_m + 1) % 16;
  endtask

  task automatic give(input logic [3:0] idx, input bit via_lsb);
    for (int k = 0; k < pending.size(); k++) begin
      if (pending[k] == idx) begin
        pending.delete(k);
        break;
      end
    end
    if (via_lsb) begin
      lsb_in_en = 1'b1; lsb_rob_idx_in = idx; lsb_val_in = res_val[idx];
    end else begin
      rs_in_en = 1'b1; rs_rob_idx_in = idx; rs_val_in = res_val[idx];
    end
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((sb.size() != 0 || pending.size() != 0) && g < 200) begin
      if (pending.size() != 0) give(pending[0], 1'b0);
      step();
      g++;
    end
    chk({"drain_timeout_", tag}, 32'(g >= 200), 32'd0);
    step();
  endtask

  task automatic random_run(input int n_instr);
    int issued = 0;
    int guard = 0;
    int kind;
    logic [31:0] pc, tgt, val;
    logic pred, taken;
    while ((issued < n_instr || sb.size() != 0 || pending.size() != 0) && guard < 5000) begin
      guard++;
      rdy_in = ($urandom_range(0, 7) != 0);
      if (rdy_in) begin
        if (pending.size() != 0 && $urandom_range(0, 2) != 0)
          give(pending[$urandom_range(0, pending.size() - 1)], 1'b0);
        if (pending.size() != 0 && $urandom_range(0, 2) != 0)
          give(pending[$urandom_range(0, pending.size() - 1)], 1'b1);
        if (!stop_disp && issued < n_instr && sb.size() < 12 && $urandom_range(0, 3) != 0) begin
          kind  = int'($urandom_range(0, 2));
          pc    = $urandom() & 32'hFFFF_FFFC;
          tgt   = $urandom() & 32'hFFFF_FFFC;
          val   = $urandom();
          pred  = 1'($urandom_range(0, 1));
          taken = ($urandom_range(0, 3) == 0) ? ~pred : pred;
          if (kind == 1) val[0] = taken;
          disp(kind, 5'($urandom_range(1, 31)), pc, pred, tgt, val);
          issued++;
        end
      end
      step();
    end
    rdy_in = 1'b1;
    chk("random_timeout", 32'(guard >= 5000), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_in) begin
      if (commit_reg_en || commit_st_en || bp_upd_en) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_commit: reg=%0d st=%0d bp=%0d idx=%0d with nothing pending",
                   commit_reg_en, commit_st_en, bp_upd_en, commit_rob_idx);
        end else begin
          m_e = sb.pop_front();
          chk("commit_reg_en", 32'(commit_reg_en), 32'(m_e.kind == 0));
          chk("commit_st_en",  32'(commit_st_en),  32'(m_e.kind == 2));
          chk("bp_upd_en",     32'(bp_upd_en),     32'(m_e.kind == 1));
          if (m_e.kind == 0) begin
            chk("commit_rd",      32'(commit_rd),      32'(m_e.rd));
            chk("commit_val",     commit_val,          m_e.val);
            chk("commit_rob_idx", 32'(commit_rob_idx), 32'(m_e.idx));
          end else if (m_e.kind == 2) begin
            chk("st_rob_idx", 32'(commit_rob_idx), 32'(m_e.idx));
          end else begin
            chk("bp_pc",     bp_pc,           m_e.pc);
            chk("bp_taken",  32'(bp_taken),   32'(m_e.taken));
            chk("roll_back", 32'(roll_back),  32'(m_e.rb));
            if (m_e.rb) chk("roll_back_pc", roll_back_pc, m_e.rb_pc);
          end
        end
      end else if (roll_back) begin
        n_checks++;
        n_fail++;
        $display("FAIL stray_roll_back: roll_back=1 without a branch commit");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    // power-up reset
    repeat (2) @(posedge clk);
    #1;
    chk("por_tail", 32'(rob_tail_idx), 32'd0);
    chk("por_full", 32'(rob_full), 32'd0);
    chk("por_pulses", 32'({commit_reg_en, commit_st_en, bp_upd_en, roll_back}), 32'd0);
    #2 rst_in = 1'b1;
    step();

    // 1: reset asserted mid-cycle while a commit pulse is visible
    disp(0, 5'd3, 32'h0, 1'b0, 32'h0, 32'hAAAA_0001);
    step();
    disp(0, 5'd4, 32'h4, 1'b0, 32'h0, 32'hBBBB_0002);
    give(4'd0, 1'b0);
    step();
    disp(0, 5'd6, 32'h8, 1'b0, 32'h0, 32'hCCCC_0003);
    give(4'd1, 1'b1);
    q1_idx_in = 4'd1;
    step();
    chk("pre_rst_commit", 32'(commit_reg_en), 32'd1);
    chk("pre_rst_q1_rdy", 32'(q1_rdy_out), 32'd1);
    chk("pre_rst_q1_val", q1_val_out, 32'hBBBB_0002);
    #2 rst_in = 1'b0;
    #1;
    chk("rst_commit_reg_en", 32'(commit_reg_en), 32'd0);
    chk("rst_commit_rd", 32'(commit_rd), 32'd0);
    chk("rst_commit_val", commit_val, 32'd0);
    chk("rst_commit_rob_idx", 32'(commit_rob_idx), 32'd0);
    chk("rst_tail", 32'(rob_tail_idx), 32'd0);
    chk("rst_q1_rdy", 32'(q1_rdy_out), 32'd0);
    chk("rst_q1_val", q1_val_out, 32'd0);
    chk("rst_misc", {26'd0, rob_full, commit_st_en, bp_upd_en, bp_taken, roll_back, 1'b0}, 32'd0);
    chk("rst_pcs", bp_pc | roll_back_pc, 32'd0);
    sb.delete();
    pending.delete();
    tail_m = 0;
    stop_disp = 0;
    q1_idx_in = 4'd0;
    @(posedge clk);
    #3 rst_in = 1'b1;
    step();

    // 2: single REG commit, one edge after capture
    disp(0, 5'd5, 32'h40, 1'b0, 32'h0, 32'h0000_1234);
    step();
    give(4'd0, 1'b0);
    step();
    chk("t2_not_early", 32'(commit_reg_en), 32'd0);
    step();
    chk("t2_commit", 32'(commit_reg_en), 32'd1);
    step();

    // 4: mispredicted branch; a dispatch in the flush cycle must be dropped
    disp(1, 5'd0, 32'h100, 1'b0, 32'h180, 32'h1);
    step();
    give(4'd1, 1'b0);
    step();
    de_in_en = 1'b1; de_type_in = 2'd0; de_rd_in = 5'd9;
    step();
    chk("t4_full_after_rb", 32'(rob_full), 32'd0);

    // 3: out-of-order completion, in-order retirement; rd=0 retires silently
    disp(0, 5'd1, 32'h200, 1'b0, 32'h0, 32'h11);
    step();
    disp(0, 5'd2, 32'h204, 1'b0, 32'h0, 32'h22);
    step();
    disp(0, 5'd3, 32'h208, 1'b0, 32'h0, 32'h33);
    step();
    give(4'd2, 1'b0);
    step();
    give(4'd1, 1'b1);
    step();
    give(4'd0, 1'b0);
    step();
    step();
    chk("t3_c0", 32'(commit_reg_en), 32'd1);
    step();
    chk("t3_c1", 32'(commit_reg_en), 32'd1);
    step();
    chk("t3_c2", 32'(commit_reg_en), 32'd1);
    step();
    chk("t3_idle", 32'(commit_reg_en), 32'd0);
    disp(0, 5'd0, 32'h20C, 1'b0, 32'h0, 32'h44);
    step();
    disp(2, 5'd0, 32'h210, 1'b0, 32'h0, 32'h55);
    step();
    disp(0, 5'd7, 32'h214, 1'b0, 32'h0, 32'h66);
    step();
    drain("t3");

    // 6: same-cycle bypass on both lookup ports, then freeze with a ready head
    b = tail_m;
    for (int i = 0; i < 4; i++) begin
      disp(0, 5'(10 + i), 32'(32'h300 + 4 * i), 1'b0, 32'h0,
           (i == 3) ? 32'd7 : (i == 2) ? 32'h55 : 32'(32'h900 + i));
      step();
    end
    q1_idx_in = 4'(b + 3);
    q2_idx_in = 4'(b + 2);
    #1;
    chk("t6_q1_not_rdy", 32'(q1_rdy_out), 32'd0);
    give(4'(b + 3), 1'b1);
    give(4'(b + 2), 1'b0);
    #1;
    chk("t6_q1_byp_rdy", 32'(q1_rdy_out), 32'd1);
    chk("t6_q1_byp_val", q1_val_out, 32'd7);
    chk("t6_q2_byp_rdy", 32'(q2_rdy_out), 32'd1);
    chk("t6_q2_byp_val", q2_val_out, 32'h55);
    step();
    #1;
    chk("t6_q1_stored_rdy", 32'(q1_rdy_out), 32'd1);
    chk("t6_q1_stored_val", q1_val_out, 32'd7);
    give(4'(b), 1'b0);
    step();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_frozen", 32'(commit_reg_en), 32'd0);
    end
    rdy_in = 1'b1;
    step();
    chk("t6_unfrozen", 32'(commit_reg_en), 32'd1);
    drain("t6");

    // 5: fill to the full threshold, then drain
    for (int i = 0; i < 14; i++) begin
      disp((i % 3 == 1) ? 2 : 0, 5'(1 + i), 32'(32'h400 + 4 * i), 1'b0, 32'h0, $urandom());
      step();
      if (i == 12) chk("t5_not_full_13", 32'(rob_full), 32'd0);
    end
    chk("t5_full_14", 32'(rob_full), 32'd1);
    while (pending.size() >= 2) begin
      give(pending[1], 1'b1);
      give(pending[0], 1'b0);
      step();
    end
    drain("t5");
    chk("t5_full_clear", 32'(rob_full), 32'd0);

    // randomized traffic with wrap-around, mispredicts and rdy_in stalls
    random_run(120);
    drain("final");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
